// File: rtl/dma_copy_engine.sv
// Word-copy DMA engine sharing CTL's single-port SRAM.
// Copies dma_len words from dma_src to dma_dst, one word per read/capture/write
// round. It only touches the SRAM in cycles where CTL is not driving it.
module dma_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [ADDR_W-1:0] dma_len,
  input  logic              ctl_sram_req,
  input  logic [DATA_W-1:0] sram_DO,
  output logic [ADDR_W-1:0] dma_sram_ADDR,
  output logic [DATA_W-1:0] dma_sram_DI,
  output logic              dma_sram_EN,
  output logic              dma_sram_WE,
  output logic              dma_busy,
  output logic [ADDR_W-1:0] dma_remaining,
  output logic              dma_done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
  } sram_req_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  sram_req_t         sram_req;

  // State and datapath registers; reset clears everything and aborts any copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and SRAM request; any cycle CTL owns the port is a stall.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    sram_req = '0;
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          src_d   = dma_src;
          dst_d   = dma_dst;
          rem_d   = dma_len;
          state_d = (dma_len != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        if (!ctl_sram_req) begin
          sram_req.en   = 1'b1;
          sram_req.addr = src_q;
          state_d       = S_CAP;
        end
      end
      S_CAP: begin
        // DO holds the word read last cycle, whoever owns the port now.
        buf_d   = sram_DO;
        state_d = S_WR;
      end
      S_WR: begin
        if (!ctl_sram_req) begin
          sram_req.en   = 1'b1;
          sram_req.we   = 1'b1;
          sram_req.addr = dst_q;
          sram_req.di   = buf_q;
          src_d         = src_q + ADDR_W'(1);
          dst_d         = dst_q + ADDR_W'(1);
          rem_d         = rem_q - ADDR_W'(1);
          state_d       = (rem_q == ADDR_W'(1)) ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Reset takes effect at the edge; suppress the access in the reset cycle
    // itself so an aborted copy never lands one more word.
    if (reset) sram_req = '0;
  end

  assign dma_sram_EN   = sram_req.en;
  assign dma_sram_WE   = sram_req.we;
  assign dma_sram_ADDR = sram_req.addr;
  assign dma_sram_DI   = sram_req.di;
  assign dma_busy      = (state_q != S_IDLE);
  assign dma_done      = (state_q == S_DONE) && !reset;
  assign dma_remaining = rem_q;

endmodule
